mem_port_arbiter: RTL and testbench

Shares one unified memory port between the instruction-fetch channel and the data-access channel of the pipelined CPU. Fetch is a read-only requester; data access issues reads and writes. The block grants one transaction at a time through a request handshake and a response handshake. Data has priority, with a starvation guard for fetch. It also keeps per-requester grant counters for the performance-counter bank.

---
 rtl/mem_port_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 699 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares a single downstream memory port between the instruction-fetch channel
// (read-only) and the data-access channel (reads and writes). One transaction
// is in flight at a time: a request phase (valid/ready) followed, for reads,
// by a response phase (rvalid/rready). Data wins arbitration, except that
// after STARVE_LIMIT data grants made while fetch was waiting, fetch is
// forced through. Per-requester grant counters feed the performance-counter
// bank.
//
// Parameters
//   STARVE_LIMIT     data grants tolerated while fetch waits (1..15)
//
// Ports
//   clk, rst         clock; synchronous active-low reset
//   inst_*           fetch request (addr/valid/ready) and response
//                    (rdata/rvalid/rready)
//   d_*              data request (addr/wdata/wstrb/memread/memwrite/ready)
//                    and response (rdata/rvalid/rready)
//   m_*              downstream request and response handshake
//   inst_grant_cnt   completed fetch request handshakes (wraps)
//   data_grant_cnt   completed data request handshakes (wraps)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] inst_addr,
    input  logic        inst_req_valid,
    output logic        inst_req_ready,
    output logic [31:0] inst_rdata,
    output logic        inst_rvalid,
    input  logic        inst_rready,

    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    input  logic        d_memread,
    input  logic        d_memwrite,
    output logic        d_req_ready,
    output logic [31:0] d_rdata,
    output logic        d_rvalid,
    input  logic        d_rready,

    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_memread,
    output logic        m_memwrite,
    input  logic        m_req_ready,
    input  logic [31:0] m_rdata,
    input  logic        m_rvalid,
    output logic        m_rready,

    output logic [31:0] inst_grant_cnt,
    output logic [31:0] data_grant_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        I_REQ = 3'd1,
        I_RSP = 3'd2,
        D_RD  = 3'd3,
        D_RSP = 3'd4,
        D_WR  = 3'd5
    } state_t;

    localparam logic [3:0] SC_MAX = 4'(STARVE_LIMIT);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] sc;          // data grants made while fetch was waiting
    logic       d_pending;
    logic       fetch_forced;
    logic       inst_hs;     // fetch request handshake this cycle
    logic       data_hs;     // data request handshake this cycle

    assign d_pending    = d_memread | d_memwrite;
    assign fetch_forced = inst_req_valid && (sc == SC_MAX);

    // Read data is a plain pass-through; rvalid alone qualifies it.
    assign inst_rdata = m_rdata;
    assign d_rdata    = m_rdata;

    // -------------------------------------------------------------------------
    // Next state and all handshake outputs. Each state only looks at its own
    // owner's inputs, so nothing on the fetch side reaches a data-side output
    // combinationally, and vice versa.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_nxt      = state;
        inst_hs        = 1'b0;
        data_hs        = 1'b0;
        inst_req_ready = 1'b0;
        inst_rvalid    = 1'b0;
        d_req_ready    = 1'b0;
        d_rvalid       = 1'b0;
        m_addr         = '0;
        m_wdata        = '0;
        m_wstrb        = '0;
        m_memread      = 1'b0;
        m_memwrite     = 1'b0;
        m_rready       = 1'b0;

        case (state)
            IDLE: begin
                // A write is served ahead of a read when both are raised.
                if (d_pending && !fetch_forced) begin
                    state_nxt = d_memwrite ? D_WR : D_RD;
                end else if (inst_req_valid) begin
                    state_nxt = I_REQ;
                end
            end

            I_REQ: begin
                m_addr         = inst_addr;
                m_memread      = inst_req_valid;
                inst_req_ready = m_req_ready;
                // A withdrawn request returns to arbitration without a grant.
                if (!inst_req_valid) begin
                    state_nxt = IDLE;
                end else if (m_req_ready) begin
                    inst_hs   = 1'b1;
                    state_nxt = I_RSP;
                end
            end

            I_RSP: begin
                m_rready    = inst_rready;
                inst_rvalid = m_rvalid;
                if (m_rvalid && inst_rready) begin
                    state_nxt = IDLE;
                end
            end

            D_RD: begin
                m_addr      = d_addr;
                m_memread   = d_memread;
                d_req_ready = m_req_ready;
                if (!d_memread) begin
                    state_nxt = IDLE;
                end else if (m_req_ready) begin
                    data_hs   = 1'b1;
                    state_nxt = D_RSP;
                end
            end

            D_RSP: begin
                m_rready = d_rready;
                d_rvalid = m_rvalid;
                if (m_rvalid && d_rready) begin
                    state_nxt = IDLE;
                end
            end

            D_WR: begin
                m_addr      = d_addr;
                m_wdata     = d_wdata;
                m_wstrb     = d_wstrb;
                m_memwrite  = d_memwrite;
                d_req_ready = m_req_ready;
                // Writes carry no response phase.
                if (!d_memwrite) begin
                    state_nxt = IDLE;
                end else if (m_req_ready) begin
                    data_hs   = 1'b1;
                    state_nxt = IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State, starve counter and grant counters. Reset drops any in-flight
    // transaction; the downstream side is reset alongside this block.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (!rst) begin
            state          <= IDLE;
            sc             <= '0;
            inst_grant_cnt <= '0;
            data_grant_cnt <= '0;
        end else begin
            state <= state_nxt;

            if (inst_hs) begin
                inst_grant_cnt <= inst_grant_cnt + 32'd1;
                sc             <= '0;
            end

            if (data_hs) begin
                data_grant_cnt <= data_grant_cnt + 32'd1;
                // Only grants that made fetch wait count toward starvation.
                if (inst_req_valid && (sc < SC_MAX)) begin
                    sc <= sc + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter. A behavioural downstream memory
// answers requests with configurable request/response latency; read data is
// addr ^ 32'hDEADBFEF. A monitor logs every downstream request handshake and
// every requester response handshake; each scenario task pushes the grants
// and responses it expects and compares them against the logs.
// Inputs change 1 time unit after posedge; outputs are sampled after negedge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_addr;
    logic        inst_req_valid;
    logic        inst_req_ready;
    logic [31:0] inst_rdata;
    logic        inst_rvalid;
    logic        inst_rready;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_memread;
    logic        d_memwrite;
    logic        d_req_ready;
    logic [31:0] d_rdata;
    logic        d_rvalid;
    logic        d_rready;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_memread;
    logic        m_memwrite;
    logic        m_req_ready;
    logic [31:0] m_rdata;
    logic        m_rvalid;
    logic        m_rready;
    logic [31:0] inst_grant_cnt;
    logic [31:0] data_grant_cnt;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk            (clk),
        .rst            (rst),
        .inst_addr      (inst_addr),
        .inst_req_valid (inst_req_valid),
        .inst_req_ready (inst_req_ready),
        .inst_rdata     (inst_rdata),
        .inst_rvalid    (inst_rvalid),
        .inst_rready    (inst_rready),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_wstrb        (d_wstrb),
        .d_memread      (d_memread),
        .d_memwrite     (d_memwrite),
        .d_req_ready    (d_req_ready),
        .d_rdata        (d_rdata),
        .d_rvalid       (d_rvalid),
        .d_rready       (d_rready),
        .m_addr         (m_addr),
        .m_wdata        (m_wdata),
        .m_wstrb        (m_wstrb),
        .m_memread      (m_memread),
        .m_memwrite     (m_memwrite),
        .m_req_ready    (m_req_ready),
        .m_rdata        (m_rdata),
        .m_rvalid       (m_rvalid),
        .m_rready       (m_rready),
        .inst_grant_cnt (inst_grant_cnt),
        .data_grant_cnt (data_grant_cnt)
    );

    // who: bit 0 = fetch, bit 1 = data
    typedef struct packed {
        logic [1:0]  who;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } grant_t;

    typedef struct packed {
        logic [1:0]  who;
        logic [31:0] data;
    } rsp_t;

    grant_t exp_g[$];
    grant_t obs_g[$];
    int     obs_g_cyc[$];
    rsp_t   exp_r[$];
    rsp_t   obs_r[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int req_lat = 0;   // cycles a visible request waits before m_req_ready
    int rsp_lat = 0;   // extra cycles between read handshake and m_rvalid

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEADBFEF;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------------------------------------------------------- memory
    initial begin
        logic        s_rst;
        logic        s_req_vis;
        logic        s_req_hs;
        logic        s_rd;
        logic        s_rsp_hs;
        logic [31:0] s_addr;
        logic        pend;
        int          rsp_cnt;
        int          wait_cnt;
        logic [31:0] pend_data;
        m_req_ready = 1'b1;
        m_rvalid    = 1'b0;
        m_rdata     = '0;
        pend        = 1'b0;
        rsp_cnt     = 0;
        wait_cnt    = 0;
        pend_data   = '0;
        forever begin
            @(negedge clk);
            s_rst     = rst;
            s_req_vis = m_memread || m_memwrite;
            s_req_hs  = s_req_vis && m_req_ready;
            s_rd      = m_memread;
            s_addr    = m_addr;
            s_rsp_hs  = m_rvalid && m_rready;
            @(posedge clk);
            #1;
            if (s_rst !== 1'b1) begin
                pend        = 1'b0;
                m_rvalid    = 1'b0;
                m_rdata     = '0;
                wait_cnt    = 0;
                m_req_ready = (req_lat == 0);
            end else begin
                if (s_rsp_hs) begin
                    m_rvalid = 1'b0;
                    m_rdata  = '0;
                end
                if (s_req_hs && s_rd) begin
                    pend      = 1'b1;
                    rsp_cnt   = rsp_lat;
                    pend_data = mem_word(s_addr);
                end
                if (pend) begin
                    if (rsp_cnt == 0) begin
                        m_rvalid = 1'b1;
                        m_rdata  = pend_data;
                        pend     = 1'b0;
                    end else begin
                        rsp_cnt--;
                    end
                end
                if (req_lat == 0) begin
                    m_req_ready = 1'b1;
                end else if (s_req_hs || !s_req_vis) begin
                    m_req_ready = 1'b0;
                    wait_cnt    = 0;
                end else begin
                    wait_cnt++;
                    if (wait_cnt >= req_lat) m_req_ready = 1'b1;
                end
            end
        end
    end

    // --------------------------------------------------------------- monitor
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                if (m_req_ready && (m_memread || m_memwrite)) begin
                    obs_g.push_back('{who: {d_req_ready, inst_req_ready}, wr: m_memwrite,
                                      addr: m_addr, wdata: m_wdata, wstrb: m_wstrb});
                    obs_g_cyc.push_back(cyc);
                end
                if (m_rvalid && m_rready) begin
                    obs_r.push_back('{who: {d_rvalid, inst_rvalid},
                                      data: inst_rvalid ? inst_rdata : d_rdata});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // --------------------------------------------------------------- helpers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst            = 1'b0;
        inst_req_valid = 1'b0;
        d_memread      = 1'b0;
        d_memwrite     = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_g.delete();
        obs_g.delete();
        obs_g_cyc.delete();
        exp_r.delete();
        obs_r.delete();
    endtask

    // ----------------------------------------------------------------- tests
    task automatic test_reset();
        req_lat = 0;
        rsp_lat = 0;
        rst            = 1'b0;
        inst_addr      = 32'h0000_0040;
        inst_req_valid = 1'b1;
        d_addr         = 32'h0000_0080;
        d_wdata        = '0;
        d_wstrb        = '0;
        d_memread      = 1'b1;
        d_memwrite     = 1'b0;
        inst_rready    = 1'b1;
        d_rready       = 1'b1;
        repeat (2) @(posedge clk);
        settle();
        checks++;
        if ({inst_req_ready, inst_rdata, inst_rvalid, d_req_ready, d_rdata, d_rvalid,
             m_addr, m_wdata, m_wstrb, m_memread, m_memwrite, m_rready} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: m_memread=%b m_addr=%h inst_req_ready=%b d_req_ready=%b m_rready=%b, all required 0",
                     m_memread, m_addr, inst_req_ready, d_req_ready, m_rready);
        end
        checks++;
        if (inst_grant_cnt !== 32'd0 || data_grant_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_counters: inst=%0d data=%0d, required 0 and 0",
                     inst_grant_cnt, data_grant_cnt);
        end
        step();
        rst = 1'b1;
        settle();
        checks++;
        if (m_memread !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_early_grant: m_memread=%b, required 0", m_memread);
        end
        step();
        settle();
        checks++;
        if (m_memread !== 1'b1 || d_req_ready !== 1'b1 || inst_req_ready !== 1'b0 ||
            m_addr !== 32'h0000_0080) begin
            errors++;
            $display("FAIL reset_first_grant: m_memread=%b d_req_ready=%b inst_req_ready=%b m_addr=%h, required 1 1 0 00000080",
                     m_memread, d_req_ready, inst_req_ready, m_addr);
        end
        step();
        inst_req_valid = 1'b0;
        d_memread      = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_lone_fetch();
        int     n_iv;
        int     n_dv;
        logic   hs_now;
        grant_t og;
        grant_t eg;
        rsp_t   orr;
        rsp_t   er;
        req_lat = 0;
        rsp_lat = 1;
        do_reset(2);
        inst_addr      = 32'h0000_0100;
        inst_req_valid = 1'b1;
        exp_g.push_back('{who: 2'b01, wr: 1'b0, addr: 32'h0000_0100, wdata: '0, wstrb: '0});
        exp_r.push_back('{who: 2'b01, data: 32'hDEADBEEF});
        n_iv = 0;
        n_dv = 0;
        for (int c = 0; c < 12; c++) begin
            settle();
            if (inst_rvalid) n_iv++;
            if (d_rvalid) n_dv++;
            hs_now = inst_req_valid && inst_req_ready;
            step();
            if (hs_now) inst_req_valid = 1'b0;
        end
        checks++;
        if (n_iv != 1) begin
            errors++;
            $display("FAIL fetch_rvalid_cycles: %0d cycles, required 1", n_iv);
        end
        checks++;
        if (n_dv != 0) begin
            errors++;
            $display("FAIL fetch_d_rvalid: %0d cycles, required 0", n_dv);
        end
        checks++;
        if (inst_grant_cnt !== 32'd1 || data_grant_cnt !== 32'd0) begin
            errors++;
            $display("FAIL fetch_counters: inst=%0d data=%0d, required 1 and 0",
                     inst_grant_cnt, data_grant_cnt);
        end
        checks++;
        if (obs_g.size() != exp_g.size() || obs_r.size() != exp_r.size()) begin
            errors++;
            $display("FAIL fetch_txn_count: grants=%0d rsps=%0d, required %0d and %0d",
                     obs_g.size(), obs_r.size(), exp_g.size(), exp_r.size());
        end
        while (obs_g.size() > 0 && exp_g.size() > 0) begin
            og = obs_g.pop_front();
            eg = exp_g.pop_front();
            checks++;
            if (og !== eg) begin
                errors++;
                $display("FAIL fetch_grant: got %h, required %h", og, eg);
            end
        end
        while (obs_r.size() > 0 && exp_r.size() > 0) begin
            orr = obs_r.pop_front();
            er  = exp_r.pop_front();
            checks++;
            if (orr !== er) begin
                errors++;
                $display("FAIL fetch_rsp: got %h, required %h", orr, er);
            end
        end
    endtask

    task automatic test_data_write();
        int     n_mw;
        int     n_mr;
        int     n_dv;
        int     n_rr;
        logic   hs_now;
        grant_t og;
        grant_t eg;
        req_lat = 3;
        rsp_lat = 0;
        do_reset(2);
        d_addr     = 32'h0000_0200;
        d_wdata    = 32'hCAFE_F00D;
        d_wstrb    = 4'b0011;
        d_memwrite = 1'b1;
        exp_g.push_back('{who: 2'b10, wr: 1'b1, addr: 32'h0000_0200,
                          wdata: 32'hCAFE_F00D, wstrb: 4'b0011});
        n_mw = 0;
        n_mr = 0;
        n_dv = 0;
        n_rr = 0;
        for (int c = 0; c < 14; c++) begin
            settle();
            if (m_memwrite) n_mw++;
            if (m_memread) n_mr++;
            if (d_rvalid) n_dv++;
            if (m_rready) n_rr++;
            hs_now = d_memwrite && d_req_ready;
            step();
            if (hs_now) d_memwrite = 1'b0;
        end
        checks++;
        if (n_mw != 4) begin
            errors++;
            $display("FAIL write_memwrite_cycles: %0d cycles, required 4", n_mw);
        end
        checks++;
        if (n_mr != 0 || n_dv != 0 || n_rr != 0) begin
            errors++;
            $display("FAIL write_no_rsp_phase: memread=%0d d_rvalid=%0d m_rready=%0d cycles, required 0 0 0",
                     n_mr, n_dv, n_rr);
        end
        checks++;
        if (data_grant_cnt !== 32'd1 || inst_grant_cnt !== 32'd0) begin
            errors++;
            $display("FAIL write_counters: data=%0d inst=%0d, required 1 and 0",
                     data_grant_cnt, inst_grant_cnt);
        end
        checks++;
        if (obs_g.size() != exp_g.size()) begin
            errors++;
            $display("FAIL write_grant_count: %0d grants, required %0d", obs_g.size(), exp_g.size());
        end
        while (obs_g.size() > 0 && exp_g.size() > 0) begin
            og = obs_g.pop_front();
            eg = exp_g.pop_front();
            checks++;
            if (og !== eg) begin
                errors++;
                $display("FAIL write_grant: got %h, required %h", og, eg);
            end
        end
    endtask

    task automatic test_abandon();
        req_lat = 3;
        rsp_lat = 0;
        do_reset(2);
        inst_addr      = 32'h0000_0300;
        inst_req_valid = 1'b1;
        step();
        settle();
        checks++;
        if (m_memread !== 1'b1 || m_addr !== 32'h0000_0300 || inst_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL abandon_fetch_driven: m_memread=%b m_addr=%h inst_req_ready=%b, required 1 00000300 0",
                     m_memread, m_addr, inst_req_ready);
        end
        step();
        inst_req_valid = 1'b0;
        d_addr         = 32'h0000_0400;
        d_memread      = 1'b1;
        step();
        settle();
        checks++;
        if (m_memread !== 1'b0) begin
            errors++;
            $display("FAIL abandon_back_to_idle: m_memread=%b, required 0", m_memread);
        end
        step();
        settle();
        checks++;
        if (m_memread !== 1'b1 || m_addr !== 32'h0000_0400) begin
            errors++;
            $display("FAIL abandon_next_grant: m_memread=%b m_addr=%h, required 1 00000400",
                     m_memread, m_addr);
        end
        checks++;
        if (inst_grant_cnt !== 32'd0 || data_grant_cnt !== 32'd0) begin
            errors++;
            $display("FAIL abandon_counters: inst=%0d data=%0d, required 0 and 0",
                     inst_grant_cnt, data_grant_cnt);
        end
        step();
        d_memread = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_starvation();
        int     bad_gap;
        grant_t og;
        grant_t eg;
        rsp_t   orr;
        rsp_t   er;
        req_lat = 0;
        rsp_lat = 0;
        do_reset(2);
        inst_addr      = 32'h0000_0500;
        d_addr         = 32'h0000_0600;
        inst_req_valid = 1'b1;
        d_memread      = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k % (STARVE_LIMIT + 1) == STARVE_LIMIT) begin
                exp_g.push_back('{who: 2'b01, wr: 1'b0, addr: 32'h0000_0500, wdata: '0, wstrb: '0});
                exp_r.push_back('{who: 2'b01, data: mem_word(32'h0000_0500)});
            end else begin
                exp_g.push_back('{who: 2'b10, wr: 1'b0, addr: 32'h0000_0600, wdata: '0, wstrb: '0});
                exp_r.push_back('{who: 2'b10, data: mem_word(32'h0000_0600)});
            end
        end
        for (int c = 0; c < 100; c++) begin
            settle();
            step();
            if (obs_g.size() >= 10) break;
        end
        inst_req_valid = 1'b0;
        d_memread      = 1'b0;
        repeat (5) step();
        bad_gap = 0;
        for (int i = 1; i < obs_g_cyc.size(); i++) begin
            if (obs_g_cyc[i] - obs_g_cyc[i-1] != 3) bad_gap++;
        end
        checks++;
        if (bad_gap != 0) begin
            errors++;
            $display("FAIL starve_read_spacing: %0d gaps differ from 3 cycles, required 0", bad_gap);
        end
        checks++;
        if (inst_grant_cnt !== 32'd2 || data_grant_cnt !== 32'd8) begin
            errors++;
            $display("FAIL starve_counters: inst=%0d data=%0d, required 2 and 8",
                     inst_grant_cnt, data_grant_cnt);
        end
        checks++;
        if (obs_g.size() != exp_g.size() || obs_r.size() != exp_r.size()) begin
            errors++;
            $display("FAIL starve_txn_count: grants=%0d rsps=%0d, required %0d and %0d",
                     obs_g.size(), obs_r.size(), exp_g.size(), exp_r.size());
        end
        while (obs_g.size() > 0 && exp_g.size() > 0) begin
            og = obs_g.pop_front();
            eg = exp_g.pop_front();
            checks++;
            if (og !== eg) begin
                errors++;
                $display("FAIL starve_grant: got %h, required %h", og, eg);
            end
        end
        while (obs_r.size() > 0 && exp_r.size() > 0) begin
            orr = obs_r.pop_front();
            er  = exp_r.pop_front();
            checks++;
            if (orr !== er) begin
                errors++;
                $display("FAIL starve_rsp: got %h, required %h", orr, er);
            end
        end
    endtask

    task automatic test_both_rw();
        int     n_mr;
        int     n_dv;
        logic   hs_now;
        grant_t og;
        grant_t eg;
        req_lat = 0;
        rsp_lat = 0;
        do_reset(2);
        d_addr     = 32'h0000_0700;
        d_wdata    = 32'h5A5A_A5A5;
        d_wstrb    = 4'b1100;
        d_memread  = 1'b1;
        d_memwrite = 1'b1;
        exp_g.push_back('{who: 2'b10, wr: 1'b1, addr: 32'h0000_0700,
                          wdata: 32'h5A5A_A5A5, wstrb: 4'b1100});
        n_mr = 0;
        n_dv = 0;
        for (int c = 0; c < 8; c++) begin
            settle();
            if (m_memread) n_mr++;
            if (d_rvalid) n_dv++;
            hs_now = d_memwrite && d_req_ready;
            step();
            if (hs_now) begin
                d_memread  = 1'b0;
                d_memwrite = 1'b0;
            end
        end
        checks++;
        if (n_mr != 0 || n_dv != 0) begin
            errors++;
            $display("FAIL rw_write_wins: m_memread=%0d d_rvalid=%0d cycles, required 0 and 0", n_mr, n_dv);
        end
        checks++;
        if (data_grant_cnt !== 32'd1) begin
            errors++;
            $display("FAIL rw_counter: data=%0d, required 1", data_grant_cnt);
        end
        checks++;
        if (obs_g.size() != exp_g.size()) begin
            errors++;
            $display("FAIL rw_grant_count: %0d grants, required %0d", obs_g.size(), exp_g.size());
        end
        while (obs_g.size() > 0 && exp_g.size() > 0) begin
            og = obs_g.pop_front();
            eg = exp_g.pop_front();
            checks++;
            if (og !== eg) begin
                errors++;
                $display("FAIL rw_grant: got %h, required %h", og, eg);
            end
        end
    endtask

    task automatic test_back_to_back();
        int     bad_gap;
        grant_t og;
        grant_t eg;
        req_lat = 0;
        rsp_lat = 0;
        do_reset(2);
        d_addr     = 32'h0000_0A00;
        d_wdata    = 32'h0BAD_F00D;
        d_wstrb    = 4'b1010;
        d_memwrite = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_g.push_back('{who: 2'b10, wr: 1'b1, addr: 32'h0000_0A00,
                              wdata: 32'h0BAD_F00D, wstrb: 4'b1010});
        end
        for (int c = 0; c < 40; c++) begin
            settle();
            step();
            if (obs_g.size() >= 3) break;
        end
        d_memwrite = 1'b0;
        repeat (3) step();
        bad_gap = 0;
        for (int i = 1; i < obs_g_cyc.size(); i++) begin
            if (obs_g_cyc[i] - obs_g_cyc[i-1] != 2) bad_gap++;
        end
        checks++;
        if (bad_gap != 0) begin
            errors++;
            $display("FAIL b2b_write_spacing: %0d gaps differ from 2 cycles, required 0", bad_gap);
        end
        checks++;
        if (data_grant_cnt !== 32'd3) begin
            errors++;
            $display("FAIL b2b_counter: data=%0d, required 3", data_grant_cnt);
        end
        checks++;
        if (obs_g.size() != exp_g.size()) begin
            errors++;
            $display("FAIL b2b_grant_count: %0d grants, required %0d", obs_g.size(), exp_g.size());
        end
        while (obs_g.size() > 0 && exp_g.size() > 0) begin
            og = obs_g.pop_front();
            eg = exp_g.pop_front();
            checks++;
            if (og !== eg) begin
                errors++;
                $display("FAIL b2b_grant: got %h, required %h", og, eg);
            end
        end
    endtask

    task automatic test_reset_in_rsp();
        logic hs_seen;
        req_lat = 0;
        rsp_lat = 6;
        do_reset(2);
        d_addr    = 32'h0000_0800;
        d_memread = 1'b1;
        hs_seen   = 1'b0;
        for (int c = 0; c < 10 && !hs_seen; c++) begin
            settle();
            hs_seen = d_memread && d_req_ready;
            step();
        end
        d_memread = 1'b0;
        settle();
        checks++;
        if (!hs_seen || m_rready !== 1'b1 || data_grant_cnt !== 32'd1) begin
            errors++;
            $display("FAIL rsp_reset_setup: handshake=%b m_rready=%b data=%0d, required 1 1 1",
                     hs_seen, m_rready, data_grant_cnt);
        end
        step();
        rst = 1'b0;
        step();
        settle();
        checks++;
        if ({inst_req_ready, inst_rdata, inst_rvalid, d_req_ready, d_rdata, d_rvalid,
             m_addr, m_wdata, m_wstrb, m_memread, m_memwrite, m_rready} !== '0) begin
            errors++;
            $display("FAIL rsp_reset_outputs: d_rvalid=%b m_rready=%b m_memread=%b, all required 0",
                     d_rvalid, m_rready, m_memread);
        end
        checks++;
        if (inst_grant_cnt !== 32'd0 || data_grant_cnt !== 32'd0) begin
            errors++;
            $display("FAIL rsp_reset_counters: inst=%0d data=%0d, required 0 and 0",
                     inst_grant_cnt, data_grant_cnt);
        end
        step();
        rst            = 1'b1;
        inst_addr      = 32'h0000_0900;
        inst_req_valid = 1'b1;
        step();
        settle();
        checks++;
        if (inst_req_ready !== 1'b1 || m_addr !== 32'h0000_0900 || d_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rsp_reset_recover: inst_req_ready=%b m_addr=%h d_rvalid=%b, required 1 00000900 0",
                     inst_req_ready, m_addr, d_rvalid);
        end
        step();
        inst_req_valid = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        test_reset();
        test_lone_fetch();
        test_data_write();
        test_abandon();
        test_starvation();
        test_both_rw();
        test_back_to_back();
        test_reset_in_rsp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
